serial_digit_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder. It adds operands DIGIT bits per clock through a registered carry,

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/adder_digit.sv | 27 ++
 rtl/serial_digit_adder.sv | 137 +++++++++++++
 tb/tb_serial_digit_adder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial digit adder: FSM state encoding and
// a helper that sizes the digit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n digits; a single-digit build still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder stages.
// Also exposes the carry into its MSB so the caller can derive signed
// overflow on the most significant digit.
module adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_stage
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (b[i] & carry[i]) | (a[i] & carry[i]);
  end

  assign cout = carry[DIGIT];
  assign cmsb = carry[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle WIDTH-bit adder that processes DIGIT bits per clock through a
// registered carry, with a Start/Busy/Done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the Sub port, which turns
// the operation into A - B (two's complement: ~B with carry-in forced to 1).
module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig_sum;
  logic                   dig_cout;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic                   last_digit;
  logic [WIDTH-1:0]       b_in;
  logic                   carry_in;

  adder_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .cin (carry_q),
    .sum (dig_sum),
    .cout(dig_cout),
    .cmsb(dig_cmsb)
  );

  // New digit enters S from the MSB side so the LSB digit ends up at the bottom after N shifts.
  assign s_cat      = {dig_sum, s_q};
  assign last_digit = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in     = Sub ? ~B : B;
  assign carry_in = Sub ? 1'b1 : Cin;
`else
  assign b_in     = B;
  assign carry_in = Cin;
`endif

  // Next-state, operand shifting and result accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          a_d     = A;
          b_d     = b_in;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = s_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_digit) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder (WIDTH=16, DIGIT=4).
// A timeline model predicts Busy/Done and the arithmetic result of each
// accepted request; directed scenarios add hand-computed expectations.
module tb_serial_digit_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  serial_digit_adder #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .Start(start),
    .A    (a),
    .B    (b),
    .Cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub  (sub),
`endif
    .Busy (busy),
    .Done (done),
    .S    (s),
    .Cout (cout),
    .Ovf  (ovf)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Plain arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic c, input logic do_sub);
    logic [WIDTH-1:0] y_eff;
    logic             c_eff;
    logic [WIDTH:0]   full;
    int               signed_sum;
    logic             v;
    y_eff      = do_sub ? ~y : y;
    c_eff      = do_sub ? 1'b1 : c;
    full       = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};
    signed_sum = int'($signed(x)) + int'($signed(y_eff)) + int'(c_eff);
    v          = (signed_sum > 32767) || (signed_sum < -32768);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  int               phase = 0;
  bit               model_on = 0;
  logic             exp_done = 1'b0;
  logic [WIDTH-1:0] exp_s = '0;
  logic             exp_cout = 1'b0;
  logic             exp_ovf = 1'b0;
  logic [WIDTH+1:0] pend = '0;

  // Timeline model: an accepted request keeps the block busy N cycles, then publishes its result.
  always @(posedge clk) begin
    logic sub_eff;
`ifdef SERIAL_ADDER_SUB_EN
    sub_eff = sub;
`else
    sub_eff = 1'b0;
`endif
    model_on = 1'b1;
    if (!rst_n) begin
      phase    = 0;
      exp_done = 1'b0;
      exp_s    = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
    end else if (phase > 0) begin
      phase--;
      if (phase == 0) begin
        exp_done = 1'b1;
        exp_s    = pend[WIDTH-1:0];
        exp_cout = pend[WIDTH];
        exp_ovf  = pend[WIDTH+1];
      end
    end else begin
      exp_done = 1'b0;
      if (start) begin
        pend  = model_add(a, b, cin, sub_eff);
        phase = N;
      end
    end
  end

  // Compare DUT against the model every cycle; S is only meaningful outside RUN.
  always @(negedge clk) begin
    if (model_on) begin
      check_value("cyc_busy", 32'(busy), 32'(phase > 0));
      check_value("cyc_done", 32'(done), 32'(exp_done));
      check_value("cyc_cout", 32'(cout), 32'(exp_cout));
      check_value("cyc_ovf", 32'(ovf), 32'(exp_ovf));
      if (phase == 0) check_value("cyc_s", 32'(s), 32'(exp_s));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic cv, input logic sv);
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for Done; latency counts the Start cycle as cycle 1.
  task automatic wait_done(input string name, input int first_lat, input int want_lat);
    int lat;
    lat = first_lat;
    while (!done && lat < 60) begin
      step();
      lat++;
    end
    check_value({name, "_latency"}, 32'(lat), 32'(want_lat));
  endtask

  task automatic check_output(input string name, input logic [WIDTH-1:0] want_s,
                              input logic want_cout, input logic want_ovf);
    check_value({name, "_s"}, 32'(s), 32'(want_s));
    check_value({name, "_cout"}, 32'(cout), 32'(want_cout));
    check_value({name, "_ovf"}, 32'(ovf), 32'(want_ovf));
  endtask

  // Directed scenarios followed by random operands.
  initial begin
    logic [WIDTH+1:0] r;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    step();
    step();
    check_value("reset_busy", 32'(busy), 32'd0);
    check_value("reset_done", 32'(done), 32'd0);
    check_output("reset", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    $display("[TB] basic add");
    apply_stimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    check_value("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 1, N + 1);
    check_output("basic", 16'h2345, 1'b0, 1'b0);
    step();
    check_value("basic_done_pulse", 32'(done), 32'd0);

    $display("[TB] wrap and overflow");
    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("wrap", 1, N + 1);
    check_output("wrap", 16'h0000, 1'b1, 1'b0);
    step();
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done("ovf", 1, N + 1);
    check_output("ovf", 16'h8000, 1'b0, 1'b1);
    step();

    $display("[TB] start during run and back-to-back");
    apply_stimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_done("ignore", 3, N + 1);
    check_output("ignore", 16'h2345, 1'b0, 1'b0);
    apply_stimulus(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
    check_value("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b", 1, N + 1);
    check_output("b2b", 16'h1001, 1'b0, 1'b0);
    step();

    $display("[TB] reset mid-run");
    apply_stimulus(16'h1234, 16'h0001, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_done", 32'(done), 32'd0);
    check_output("abort", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_value("abort_no_done", 32'(done), 32'd0);
    end
    apply_stimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_done("after_abort", 1, N + 1);
    check_output("after_abort", 16'h0000, 1'b1, 1'b1);
    step();

    $display("[TB] carry-in");
    apply_stimulus(16'hABCD, 16'h1234, 1'b1, 1'b0);
    wait_done("cin", 1, N + 1);
    check_output("cin", 16'hBE02, 1'b0, 1'b0);
    step();

`ifdef SERIAL_ADDER_SUB_EN
    $display("[TB] subtract");
    apply_stimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("sub_neg", 1, N + 1);
    check_output("sub_neg", 16'hFFFE, 1'b0, 1'b0);
    step();
    apply_stimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
    wait_done("sub_zero", 1, N + 1);
    check_output("sub_zero", 16'h0000, 1'b1, 1'b0);
    step();
`endif

    $display("[TB] random operands");
    for (int i = 0; i < 12; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      r  = model_add(ra, rb, rc, 1'b0);
      apply_stimulus(ra, rb, rc, 1'b0);
      wait_done("rand", 1, N + 1);
      check_output("rand", r[WIDTH-1:0], r[WIDTH], r[WIDTH+1]);
      if (i % 3 == 0) step();
    end
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
